// File: rtl/axis_packet_generator_if.sv
// AXI4-Stream bundle between the packet generator (master) and the ingress bridge (slave).
interface axis_packet_generator_if #(
  parameter int DATA_W = 64,
  parameter int ID_W   = 8,
  parameter int DEST_W = 4,
  parameter int USER_W = 8
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic [ID_W-1:0]     tid;
  logic [DEST_W-1:0]   tdest;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;

  modport master (
    output tdata, tstrb, tkeep, tlast, tid, tdest, tuser, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tkeep, tlast, tid, tdest, tuser, tvalid,
    output tready
  );
endinterface

// File: rtl/axis_packet_generator.sv
// Programmable AXI4-Stream packet burst source with self-describing counter payload.
// Define AXIS_GEN_LFSR_EN to replace the counter payload with a 64-bit Galois LFSR stream.
module axis_packet_generator #(
  parameter int DATA_W     = 64,
  parameter int ID_W       = 8,
  parameter int DEST_W     = 4,
  parameter int USER_W     = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [7:0]          cfg_len_m1,
  input  logic [15:0]         cfg_num_pkts,
  input  logic [DEST_W-1:0]   cfg_dest,
  input  logic [ID_W-1:0]     cfg_id,
  input  logic [DATA_W/8-1:0] cfg_last_keep,
  axis_packet_generator_if.master axis,
  output logic                busy,
  output logic                done,
  output logic [15:0]         pkt_count
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int REPS   = (DATA_W + 63) / 64;

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

  state_t            state;
  logic [7:0]        len_m1;
  logic [15:0]       num_pkts;
  logic [KEEP_W-1:0] last_keep;
  logic [7:0]        beat_idx;
  logic [31:0]       pkt_seq;
  logic [15:0]       gap_cnt;

  logic        fire;
  logic [7:0]  next_beat;
  logic [31:0] next_seq;
  logic [15:0] count_inc;
  logic        burst_end;
  logic [63:0] word_start;
  logic [63:0] word_fire;

  function automatic logic [DATA_W-1:0] expand(input logic [63:0] w);
    return DATA_W'({REPS{w}});
  endfunction

  assign fire      = axis.tvalid && axis.tready;
  assign next_beat = beat_idx + 8'd1;
  assign next_seq  = pkt_seq + 32'd1;
  assign count_inc = (pkt_count == 16'hFFFF) ? pkt_count : pkt_count + 16'd1;
  assign burst_end = (17'(pkt_count) + 17'd1 == 17'(num_pkts)) || abort;

`ifdef AXIS_GEN_LFSR_EN
  logic [63:0] lfsr;
  logic [63:0] lfsr_next;
  logic [63:0] lfsr_seed;

  // Right-shifting Galois form of x^64+x^63+x^61+x^60+1; only advances on a handshake.
  assign lfsr_next  = {1'b0, lfsr[63:1]} ^ (lfsr[0] ? 64'hD800_0000_0000_0000 : 64'h0);
  assign lfsr_seed  = 64'h1 ^ 64'({cfg_id, cfg_dest});
  assign word_start = lfsr_seed;
  assign word_fire  = lfsr_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= '0;
    end else if (state == IDLE && start) begin
      lfsr <= lfsr_seed;
    end else if (fire) begin
      lfsr <= lfsr_next;
    end
  end
`else
  assign word_start = {pkt_seq, 32'h0};
  assign word_fire  = axis.tlast ? {next_seq, 32'h0} : {pkt_seq, 24'h0, next_beat};
`endif

  // Payload for the next beat is loaded on the handshake that retires the current one,
  // so every field stays put while tready is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len_m1      <= '0;
      num_pkts    <= '0;
      last_keep   <= '0;
      beat_idx    <= '0;
      pkt_seq     <= '0;
      gap_cnt     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pkt_count   <= '0;
      axis.tdata  <= '0;
      axis.tstrb  <= '0;
      axis.tkeep  <= '0;
      axis.tlast  <= 1'b0;
      axis.tid    <= '0;
      axis.tdest  <= '0;
      axis.tuser  <= '0;
      axis.tvalid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_m1    <= cfg_len_m1;
            num_pkts  <= cfg_num_pkts;
            last_keep <= cfg_last_keep;
            axis.tid  <= cfg_id;
            axis.tdest <= cfg_dest;
            beat_idx  <= '0;
            pkt_count <= '0;
            busy      <= 1'b1;
            if (cfg_num_pkts != 16'd0) begin
              state       <= SEND;
              axis.tvalid <= 1'b1;
              axis.tdata  <= expand(word_start);
              axis.tlast  <= (cfg_len_m1 == 8'd0);
              axis.tkeep  <= (cfg_len_m1 == 8'd0) ? cfg_last_keep : {KEEP_W{1'b1}};
              axis.tstrb  <= (cfg_len_m1 == 8'd0) ? cfg_last_keep : {KEEP_W{1'b1}};
              axis.tuser  <= USER_W'(pkt_seq);
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        SEND: begin
          if (fire) begin
            axis.tdata <= expand(word_fire);
            if (axis.tlast) begin
              beat_idx   <= '0;
              pkt_seq    <= next_seq;
              pkt_count  <= count_inc;
              axis.tlast <= (len_m1 == 8'd0);
              axis.tkeep <= (len_m1 == 8'd0) ? last_keep : {KEEP_W{1'b1}};
              axis.tstrb <= (len_m1 == 8'd0) ? last_keep : {KEEP_W{1'b1}};
              axis.tuser <= USER_W'(next_seq);
              if (burst_end) begin
                state       <= FIN;
                axis.tvalid <= 1'b0;
                done        <= 1'b1;
              end else if (GAP_CYCLES > 0) begin
                state       <= GAP;
                axis.tvalid <= 1'b0;
                gap_cnt     <= 16'(GAP_CYCLES - 1);
              end
            end else begin
              beat_idx   <= next_beat;
              axis.tlast <= (next_beat == len_m1);
              axis.tkeep <= (next_beat == len_m1) ? last_keep : {KEEP_W{1'b1}};
              axis.tstrb <= (next_beat == len_m1) ? last_keep : {KEEP_W{1'b1}};
            end
          end
        end
        GAP: begin
          if (abort) begin
            state <= FIN;
            done  <= 1'b1;
          end else if (gap_cnt == 16'd0) begin
            state       <= SEND;
            axis.tvalid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_packet_generator.sv
// Bench for axis_packet_generator: one instance with back-to-back packets, one with a 2-cycle gap.
module tb_axis_packet_generator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cfg_len_m1 = '0;
  logic [15:0] cfg_num_pkts = '0;
  logic [3:0]  cfg_dest = '0;
  logic [7:0]  cfg_id = '0;
  logic [7:0]  cfg_last_keep = '0;
  logic        tready = 1'b1;
  logic        rand_ready = 1'b0;

  logic        busy0, done0, busy2, done2;
  logic [15:0] cnt0, cnt2;

  always #5 clk = ~clk;

  axis_packet_generator_if ax0 ();
  axis_packet_generator_if ax2 ();
  assign ax0.tready = tready;
  assign ax2.tready = tready;

  axis_packet_generator #(.GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_len_m1(cfg_len_m1), .cfg_num_pkts(cfg_num_pkts), .cfg_dest(cfg_dest),
    .cfg_id(cfg_id), .cfg_last_keep(cfg_last_keep), .axis(ax0),
    .busy(busy0), .done(done0), .pkt_count(cnt0)
  );

  axis_packet_generator #(.GAP_CYCLES(2)) dut_g2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_len_m1(cfg_len_m1), .cfg_num_pkts(cfg_num_pkts), .cfg_dest(cfg_dest),
    .cfg_id(cfg_id), .cfg_last_keep(cfg_last_keep), .axis(ax2),
    .busy(busy2), .done(done2), .pkt_count(cnt2)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [7:0]  keep;
    logic [7:0]  user;
  } beat_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [7:0]  keep;
    logic [7:0]  user;
    int          cyc;
  } fire_t;

  beat_t exp_q [2][$];
  fire_t log_q [2][$];
  int    idle_cnt [2];
  logic  new_beat [2];
  logic  first_beat [2];
  logic  last_was_tlast [2];
  int    done_cnt [2];
  int    done_cyc [2];
  int    gap_of [2] = '{0, 2};
  logic [7:0] exp_id;
  logic [3:0] exp_dest;
  int    model_seq = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    total = 0;
  int    passed = 0;

  task automatic check_value(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Expected beats come straight from the payload rules: {seq, beat} words, seq per packet.
  task automatic build_burst(input logic [7:0] len, input int npk, input logic [7:0] keep);
    beat_t b;
    for (int p = 0; p < npk; p++) begin
      for (int k = 0; k <= int'(len); k++) begin
        b.data = {32'(model_seq), 32'(k)};
        b.last = (k == int'(len));
        b.keep = (k == int'(len)) ? keep : 8'hFF;
        b.user = 8'(model_seq);
        exp_q[0].push_back(b);
        exp_q[1].push_back(b);
      end
      model_seq++;
    end
  endtask

  task automatic check_dut(input int d, input logic tv, input logic tr, input logic [63:0] td,
                           input logic [7:0] tk, input logic [7:0] ts, input logic tl,
                           input logic [7:0] ti, input logic [3:0] tdst, input logic [7:0] tu,
                           input logic bz, input logic dn);
    beat_t e;
    fire_t f;
    int    exp_idle;
    if (dn) begin
      done_cnt[d]++;
      done_cyc[d] = cyc;
    end
    if (tv) begin
      if (new_beat[d]) begin
        exp_idle = (!first_beat[d] && last_was_tlast[d]) ? gap_of[d] : 0;
        check_value(d == 0 ? "idle_before_beat_g0" : "idle_before_beat_g2", 128'(idle_cnt[d]), 128'(exp_idle));
        new_beat[d] = 1'b0;
        first_beat[d] = 1'b0;
      end
      check_value("tstrb_eq_tkeep", 128'(ts), 128'(tk));
      if (exp_q[d].size() == 0) begin
        check_value("extra_beat", 128'(tv), 128'(0));
      end else begin
        e = exp_q[d][0];
        check_value(d == 0 ? "beat_g0" : "beat_g2", {td, tl, tk, tu, ti, tdst},
                    {e.data, e.last, e.keep, e.user, exp_id, exp_dest});
        if (tr) begin
          void'(exp_q[d].pop_front());
          f.data = td; f.last = tl; f.keep = tk; f.user = tu; f.cyc = cyc;
          log_q[d].push_back(f);
          last_was_tlast[d] = tl;
          idle_cnt[d] = 0;
          new_beat[d] = 1'b1;
        end
      end
    end else if (bz) begin
      idle_cnt[d]++;
    end
  endtask

  // Single compare point, half a cycle away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check_dut(0, ax0.tvalid, ax0.tready, ax0.tdata, ax0.tkeep, ax0.tstrb, ax0.tlast,
                ax0.tid, ax0.tdest, ax0.tuser, busy0, done0);
      check_dut(1, ax2.tvalid, ax2.tready, ax2.tdata, ax2.tkeep, ax2.tstrb, ax2.tlast,
                ax2.tid, ax2.tdest, ax2.tuser, busy2, done2);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic apply_stimulus(input logic [7:0] len, input logic [15:0] npk, input logic [7:0] keep,
                                input int exp_pkts, input logic [3:0] dest, input logic [7:0] id);
    @(posedge clk);
    #1;
    cfg_len_m1 = len; cfg_num_pkts = npk; cfg_last_keep = keep;
    cfg_dest = dest; cfg_id = id; start = 1'b1;
    exp_id = id; exp_dest = dest;
    start_cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      log_q[d].delete();
      idle_cnt[d] = 0; new_beat[d] = 1'b1; first_beat[d] = 1'b1;
      last_was_tlast[d] = 1'b0; done_cnt[d] = 0; done_cyc[d] = 0;
    end
    build_burst(len, exp_pkts, keep);
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble the config so that any late sampling shows up as wrong payload.
    cfg_len_m1 = ~len; cfg_num_pkts = ~npk; cfg_last_keep = ~keep;
    cfg_dest = ~dest; cfg_id = ~id;
  endtask

  task automatic wait_bursts(input int budget);
    int k = 0;
    while ((done_cnt[0] == 0 || done_cnt[1] == 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    check_value("done_seen_in_budget", 128'(done_cnt[0] != 0 && done_cnt[1] != 0), 128'(1));
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input logic [15:0] exp_cnt);
    check_value("beats_left_g0", 128'(exp_q[0].size()), 128'(0));
    check_value("beats_left_g2", 128'(exp_q[1].size()), 128'(0));
    check_value("done_pulses_g0", 128'(done_cnt[0]), 128'(1));
    check_value("done_pulses_g2", 128'(done_cnt[1]), 128'(1));
    check_value("pkt_count_g0", 128'(cnt0), 128'(exp_cnt));
    check_value("pkt_count_g2", 128'(cnt2), 128'(exp_cnt));
    check_value("busy_idle", 128'({busy0, busy2}), 128'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    check_value("reset_axis_g0", {ax0.tvalid, ax0.tdata, ax0.tkeep, ax0.tstrb, ax0.tlast, ax0.tuser}, 128'(0));
    check_value("reset_axis_g2", {ax2.tvalid, ax2.tdata, ax2.tkeep, ax2.tstrb, ax2.tlast, ax2.tuser}, 128'(0));
    check_value("reset_status", {busy0, done0, cnt0, busy2, done2, cnt2}, 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Two 4-beat packets with tready high; a start mid-burst must be ignored.
    tready = 1'b1;
    apply_stimulus(8'd3, 16'd2, 8'hFF, 2, 4'h5, 8'hA7);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_bursts(100);
    check_output(16'd2);
    check_value("t1_beats_g0", 128'(log_q[0].size()), 128'(8));
    if (log_q[0].size() == 8) begin
      check_value("t1_first_latency", 128'(log_q[0][0].cyc), 128'(start_cyc + 1));
      check_value("t1_beat5_data", 128'(log_q[0][5].data), 128'(64'h0000_0001_0000_0001));
      check_value("t1_tlast_pattern", 128'({log_q[0][7].last, log_q[0][4].last, log_q[0][3].last, log_q[0][2].last}), 128'(4'b1010));
      check_value("t1_tuser", 128'({log_q[0][0].user, log_q[0][4].user}), 128'(16'h0001));
      check_value("t1_done_timing", 128'(done_cyc[0]), 128'(log_q[0][7].cyc + 1));
    end
    if (log_q[1].size() == 8)
      check_value("t1_gap_spacing", 128'(log_q[1][4].cyc - log_q[1][3].cyc), 128'(3));

    // Single-beat packets, partial keep on every beat.
    apply_stimulus(8'd0, 16'd3, 8'h0F, 3, 4'h2, 8'h11);
    wait_bursts(100);
    check_output(16'd3);
    if (log_q[1].size() == 3 && log_q[0].size() == 3) begin
      check_value("t2_gap_span", 128'(log_q[1][2].cyc - log_q[1][0].cyc), 128'(6));
      check_value("t2_b2b_span", 128'(log_q[0][2].cyc - log_q[0][0].cyc), 128'(2));
      check_value("t2_keep_last", 128'({log_q[0][1].keep, log_q[0][1].last}), 128'({8'h0F, 1'b1}));
    end

    // Random backpressure, 8-beat packets.
    rand_ready = 1'b1;
    apply_stimulus(8'd7, 16'd2, 8'h0F, 2, 4'h9, 8'h3C);
    wait_bursts(600);
    rand_ready = 1'b0;
    tready = 1'b1;
    check_output(16'd2);
    check_value("t3_fires_g0", 128'(log_q[0].size()), 128'(16));
    if (log_q[0].size() == 16)
      check_value("t3_beat9_data", 128'(log_q[0][9].data), 128'(64'h0000_0006_0000_0001));

    // Abort during beat 1 of packet 0: that packet finishes, nothing after it.
    apply_stimulus(8'd3, 16'd5, 8'hFF, 1, 4'h1, 8'h42);
    @(posedge clk);
    #1;
    abort = 1'b1;
    wait_bursts(100);
    abort = 1'b0;
    check_output(16'd1);
    check_value("t4_fires_g2", 128'(log_q[1].size()), 128'(4));

    // Zero-packet burst: FIN straight away, no beats.
    apply_stimulus(8'd3, 16'd0, 8'hFF, 0, 4'h7, 8'h77);
    #2;
    check_value("t5_fin_cycle", 128'({busy0, done0, ax0.tvalid, busy2, done2, ax2.tvalid}), 128'(6'b110110));
    @(posedge clk);
    #3;
    check_value("t5_after_fin", 128'({busy0, done0, ax0.tvalid, busy2, done2, ax2.tvalid}), 128'(0));
    wait_bursts(20);
    check_output(16'd0);

    // Asynchronous reset in the middle of a packet.
    apply_stimulus(8'd7, 16'd2, 8'hFF, 2, 4'h3, 8'h99);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_value("t6_rst_axis_g0", {ax0.tvalid, ax0.tdata, ax0.tkeep, ax0.tlast, ax0.tuser}, 128'(0));
    check_value("t6_rst_status", {busy0, cnt0, ax2.tvalid, busy2, cnt2}, 128'(0));
    exp_q[0].delete();
    exp_q[1].delete();
    model_seq = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus(8'd1, 16'd1, 8'h0F, 1, 4'h6, 8'h5A);
    wait_bursts(50);
    check_output(16'd1);
    if (log_q[0].size() == 2) begin
      check_value("t6_restart_data", {log_q[0][0].data, log_q[0][1].data}, {64'h0, 64'h1});
      check_value("t6_keep", 128'({log_q[0][0].keep, log_q[0][1].keep}), 128'(16'hFF0F));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
